// File: rtl/cpu_run_ctrl_if.sv
// Bus between the run controller and the CPU/bench side.
// Carries the write-capture channels, the trace stream and the run status.
interface cpu_run_ctrl_if #(
  parameter int unsigned CNT_W = 32
);
  logic             cpu_reset;
  logic [31:0]      pc_in;
  logic             grf_we;
  logic [4:0]       grf_addr;
  logic [31:0]      grf_wdata;
  logic             dm_we;
  logic [31:0]      dm_addr;
  logic [31:0]      dm_wdata;
  logic             trace_valid;
  logic             trace_ready;
  logic             trace_kind;
  logic [31:0]      trace_pc;
  logic [31:0]      trace_addr;
  logic [31:0]      trace_data;
  logic [CNT_W-1:0] cycle_cnt;
  logic             running;
  logic             done;
  logic             timeout;
  logic             overflow;

  // CPU / bench side
  modport master (
    input  cpu_reset, trace_valid, trace_kind, trace_pc, trace_addr, trace_data,
           cycle_cnt, running, done, timeout, overflow,
    output pc_in, grf_we, grf_addr, grf_wdata, dm_we, dm_addr, dm_wdata, trace_ready
  );

  // Run controller side
  modport slave (
    output cpu_reset, trace_valid, trace_kind, trace_pc, trace_addr, trace_data,
           cycle_cnt, running, done, timeout, overflow,
    input  pc_in, grf_we, grf_addr, grf_wdata, dm_we, dm_addr, dm_wdata, trace_ready
  );
endinterface

// File: rtl/cpu_run_ctrl.sv
// Run controller for a CPU under test: stretched CPU reset, cycle counting,
// halt/timeout detection and a FIFO-buffered GRF/DM write trace.
module cpu_run_ctrl #(
  parameter int unsigned RST_CYCLES  = 5,
  parameter int unsigned TIMEOUT     = 100000,
  parameter int unsigned HALT_REPEAT = 4,
  parameter int unsigned FIFO_DEPTH  = 8,
  parameter int unsigned CNT_W       = 32
) (
  input  logic         clk,
  input  logic         reset,
  cpu_run_ctrl_if.slave bus
);

  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned OCC_W  = PTR_W + 1;
  localparam int unsigned HOLD_W = $clog2(RST_CYCLES + 1);
  localparam int unsigned HALT_W = $clog2(HALT_REPEAT);

  typedef enum logic [2:0] {
    ST_HOLD  = 3'd0,
    ST_RUN   = 3'd1,
    ST_DRAIN = 3'd2,
    ST_DONE  = 3'd3,
    ST_TOUT  = 3'd4
  } state_e;

  typedef struct packed {
    logic        kind;
    logic [31:0] pc;
    logic [31:0] addr;
    logic [31:0] data;
  } trace_entry_t;

  state_e             state_q, state_d;
  logic [HOLD_W-1:0]  hold_cnt_q, hold_cnt_d;
  logic [HALT_W-1:0]  halt_cnt_q, halt_cnt_d;
  logic               tout_tag_q, tout_tag_d;
  logic [31:0]        prev_pc_q;
  logic [CNT_W-1:0]   cycle_cnt_q, cycle_cnt_d;
  logic               overflow_q, overflow_d;
  logic               cpu_reset_q, cpu_reset_d;
  logic               running_q, running_d;
  logic               done_q, done_d;
  logic               timeout_q, timeout_d;

  trace_entry_t       mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0]   occ_q, occ_d;

  logic               capture;
  logic               grf_ok;
  logic               dm_ok;
  logic               pop;
  logic [OCC_W-1:0]   need;
  logic [OCC_W-1:0]   free_slots;
  logic               push_ok;
  logic               drop;
  logic               pc_same;
  logic [PTR_W-1:0]   dm_slot;
  trace_entry_t       grf_entry;
  trace_entry_t       dm_entry;
  trace_entry_t       head;

  // Capture and FIFO bookkeeping
  always_comb begin
    capture    = (state_q == ST_RUN);
    grf_ok     = capture && bus.grf_we && (bus.grf_addr != 5'd0);
    dm_ok      = capture && bus.dm_we;
    pop        = (occ_q != OCC_W'(0)) && bus.trace_ready;
    need       = OCC_W'(grf_ok) + OCC_W'(dm_ok);
    // a same-cycle pop frees its slot for this cycle's writes
    free_slots = OCC_W'(FIFO_DEPTH) - occ_q + OCC_W'(pop);
    push_ok    = (need != OCC_W'(0)) && (need <= free_slots);
    drop       = (need != OCC_W'(0)) && !push_ok;
    dm_slot    = grf_ok ? (wr_ptr_q + PTR_W'(1)) : wr_ptr_q;

    grf_entry  = '{kind: 1'b0, pc: bus.pc_in, addr: {27'd0, bus.grf_addr}, data: bus.grf_wdata};
    dm_entry   = '{kind: 1'b1, pc: bus.pc_in, addr: bus.dm_addr, data: bus.dm_wdata};

    wr_ptr_d   = push_ok ? (wr_ptr_q + PTR_W'(need)) : wr_ptr_q;
    rd_ptr_d   = rd_ptr_q + PTR_W'(pop);
    occ_d      = occ_q + (push_ok ? need : OCC_W'(0)) - OCC_W'(pop);
    overflow_d = overflow_q | drop;

    cycle_cnt_d = cycle_cnt_q;
    if (capture && (cycle_cnt_q != {CNT_W{1'b1}})) begin
      cycle_cnt_d = cycle_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      if (grf_ok) begin
        mem_q[wr_ptr_q] <= grf_entry;
      end
      if (dm_ok) begin
        mem_q[dm_slot] <= dm_entry;
      end
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_HOLD;
      hold_cnt_q <= '0;
      halt_cnt_q <= '0;
      tout_tag_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
      halt_cnt_q <= halt_cnt_d;
      tout_tag_q <= tout_tag_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    halt_cnt_d = halt_cnt_q;
    tout_tag_d = tout_tag_q;
    pc_same    = (bus.pc_in == prev_pc_q);

    unique case (state_q)
      ST_HOLD: begin
        if (hold_cnt_q == HOLD_W'(RST_CYCLES)) begin
          state_d = ST_RUN;
        end else begin
          hold_cnt_d = hold_cnt_q + HOLD_W'(1);
        end
      end
      ST_RUN: begin
        halt_cnt_d = pc_same ? (halt_cnt_q + HALT_W'(1)) : '0;
        // halt has priority over a coincident timeout
        if (pc_same && (halt_cnt_q == HALT_W'(HALT_REPEAT - 2))) begin
          state_d    = ST_DRAIN;
          tout_tag_d = 1'b0;
        end else if (cycle_cnt_q == CNT_W'(TIMEOUT - 1)) begin
          state_d    = ST_DRAIN;
          tout_tag_d = 1'b1;
        end
      end
      ST_DRAIN: begin
        if (occ_q == OCC_W'(0)) begin
          state_d = tout_tag_q ? ST_TOUT : ST_DONE;
        end
      end
      ST_DONE: state_d = ST_DONE;
      ST_TOUT: state_d = ST_TOUT;
      default: state_d = ST_HOLD;
    endcase
  end

  // Output decode, registered below alongside the datapath
  always_comb begin
    cpu_reset_d = (state_d != ST_RUN);
    running_d   = (state_d == ST_RUN);
    done_d      = (state_d == ST_DONE);
    timeout_d   = (state_d == ST_TOUT);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prev_pc_q   <= '0;
      cycle_cnt_q <= '0;
      overflow_q  <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      occ_q       <= '0;
      cpu_reset_q <= 1'b1;
      running_q   <= 1'b0;
      done_q      <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      prev_pc_q   <= bus.pc_in;
      cycle_cnt_q <= cycle_cnt_d;
      overflow_q  <= overflow_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      occ_q       <= occ_d;
      cpu_reset_q <= cpu_reset_d;
      running_q   <= running_d;
      done_q      <= done_d;
      timeout_q   <= timeout_d;
    end
  end

  assign head            = mem_q[rd_ptr_q];
  assign bus.trace_valid = (occ_q != OCC_W'(0));
  assign bus.trace_kind  = head.kind;
  assign bus.trace_pc    = head.pc;
  assign bus.trace_addr  = head.addr;
  assign bus.trace_data  = head.data;
  assign bus.cpu_reset   = cpu_reset_q;
  assign bus.cycle_cnt   = cycle_cnt_q;
  assign bus.running     = running_q;
  assign bus.done        = done_q;
  assign bus.timeout     = timeout_q;
  assign bus.overflow    = overflow_q;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Directed bench for cpu_run_ctrl: a main instance for trace/halt behaviour and
// a short-timeout instance that runs alongside with an ever-changing PC.
module tb_cpu_run_ctrl;

  logic        clk;
  logic        reset;
  logic        hold_pc;
  logic [31:0] p;
  int          n_cmp;
  int          n_err;

  cpu_run_ctrl_if #(.CNT_W(32)) m_if ();
  cpu_run_ctrl_if #(.CNT_W(32)) t_if ();

  cpu_run_ctrl #(
    .RST_CYCLES(5), .TIMEOUT(1000), .HALT_REPEAT(4), .FIFO_DEPTH(8), .CNT_W(32)
  ) dut (
    .clk(clk), .reset(reset), .bus(m_if)
  );

  cpu_run_ctrl #(
    .RST_CYCLES(5), .TIMEOUT(20), .HALT_REPEAT(4), .FIFO_DEPTH(8), .CNT_W(32)
  ) dut_to (
    .clk(clk), .reset(reset), .bus(t_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock; outputs are sampled and inputs driven 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
    if (!hold_pc) m_if.pc_in = m_if.pc_in + 32'd4;
    t_if.pc_in = t_if.pc_in + 32'd4;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    hold_pc = 1'b0;
    p = '0;
    reset = 1'b1;
    m_if.pc_in = '0; m_if.grf_we = 1'b0; m_if.grf_addr = '0; m_if.grf_wdata = '0;
    m_if.dm_we = 1'b0; m_if.dm_addr = '0; m_if.dm_wdata = '0; m_if.trace_ready = 1'b0;
    t_if.pc_in = 32'h100; t_if.grf_we = 1'b0; t_if.grf_addr = '0; t_if.grf_wdata = '0;
    t_if.dm_we = 1'b0; t_if.dm_addr = '0; t_if.dm_wdata = '0; t_if.trace_ready = 1'b1;

    // reset state
    repeat (3) tick();
    chk("rst_cpu_reset", 32'(m_if.cpu_reset), 32'd1);
    chk("rst_running",   32'(m_if.running),   32'd0);
    chk("rst_valid",     32'(m_if.trace_valid), 32'd0);
    chk("rst_cycle",     m_if.cycle_cnt,      32'd0);
    chk("rst_flags",     {29'd0, m_if.done, m_if.timeout, m_if.overflow}, 32'd0);

    // CPU reset stretched for 5 edges, RUN on the 6th
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("hold_cpu_reset", 32'(m_if.cpu_reset), 32'd1);
      chk("hold_running",   32'(m_if.running),   32'd0);
    end
    tick();
    chk("run_running",   32'(m_if.running),   32'd1);
    chk("run_cpu_reset", 32'(m_if.cpu_reset), 32'd0);
    chk("run_cycle0",    m_if.cycle_cnt,      32'd0);
    chk("to_running",    32'(t_if.running),   32'd1);

    // single GRF write, then a write to $0
    m_if.pc_in = 32'h3000; m_if.grf_we = 1'b1; m_if.grf_addr = 5'd8;
    m_if.grf_wdata = 32'h1234; m_if.trace_ready = 1'b1;
    tick();
    m_if.grf_addr = 5'd0; m_if.grf_wdata = 32'hdead;
    chk("g_valid", 32'(m_if.trace_valid), 32'd1);
    chk("g_kind",  32'(m_if.trace_kind),  32'd0);
    chk("g_pc",    m_if.trace_pc,   32'h3000);
    chk("g_addr",  m_if.trace_addr, 32'd8);
    chk("g_data",  m_if.trace_data, 32'h1234);
    chk("g_cycle", m_if.cycle_cnt,  32'd1);
    tick();
    m_if.grf_we = 1'b0;
    chk("r0_valid",    32'(m_if.trace_valid), 32'd0);
    chk("r0_overflow", 32'(m_if.overflow),    32'd0);

    // dual write, GRF first, head held while not ready
    m_if.trace_ready = 1'b0;
    m_if.grf_we = 1'b1; m_if.grf_addr = 5'd1; m_if.grf_wdata = 32'hA;
    m_if.dm_we = 1'b1; m_if.dm_addr = 32'h10; m_if.dm_wdata = 32'hB;
    p = m_if.pc_in;
    tick();
    m_if.grf_we = 1'b0; m_if.dm_we = 1'b0;
    chk("d_valid", 32'(m_if.trace_valid), 32'd1);
    chk("d_kind0", 32'(m_if.trace_kind),  32'd0);
    chk("d_addr0", m_if.trace_addr, 32'd1);
    chk("d_data0", m_if.trace_data, 32'hA);
    chk("d_pc0",   m_if.trace_pc,   p);
    tick();
    chk("d_hold_kind", 32'(m_if.trace_kind), 32'd0);
    chk("d_hold_data", m_if.trace_data, 32'hA);
    m_if.trace_ready = 1'b1;
    tick();
    chk("d_kind1", 32'(m_if.trace_kind), 32'd1);
    chk("d_addr1", m_if.trace_addr, 32'h10);
    chk("d_data1", m_if.trace_data, 32'hB);
    chk("d_pc1",   m_if.trace_pc,   p);
    tick();
    chk("d_empty", 32'(m_if.trace_valid), 32'd0);

    // fill to 7, dual write drops, then dual write with a same-cycle pop fits
    m_if.trace_ready = 1'b0;
    for (int i = 1; i <= 7; i++) begin
      m_if.grf_we = 1'b1; m_if.grf_addr = 5'(i); m_if.grf_wdata = 32'(i);
      tick();
    end
    m_if.grf_we = 1'b1; m_if.grf_addr = 5'd20; m_if.grf_wdata = 32'hD0;
    m_if.dm_we = 1'b1; m_if.dm_addr = 32'h40; m_if.dm_wdata = 32'hD1;
    tick();
    chk("ov_flag", 32'(m_if.overflow),  32'd1);
    chk("ov_head", m_if.trace_data,     32'd1);
    m_if.grf_addr = 5'd21; m_if.grf_wdata = 32'hE0;
    m_if.dm_addr = 32'h44; m_if.dm_wdata = 32'hE1;
    m_if.trace_ready = 1'b1;
    tick();
    m_if.grf_we = 1'b0; m_if.dm_we = 1'b0;
    for (int i = 2; i <= 7; i++) begin
      chk("ov_seq_valid", 32'(m_if.trace_valid), 32'd1);
      chk("ov_seq_data",  m_if.trace_data, 32'(i));
      tick();
    end
    chk("ov_e0_kind", 32'(m_if.trace_kind), 32'd0);
    chk("ov_e0_addr", m_if.trace_addr, 32'd21);
    chk("ov_e0_data", m_if.trace_data, 32'hE0);
    tick();
    chk("ov_e1_kind", 32'(m_if.trace_kind), 32'd1);
    chk("ov_e1_addr", m_if.trace_addr, 32'h44);
    chk("ov_e1_data", m_if.trace_data, 32'hE1);
    tick();
    chk("ov_empty", 32'(m_if.trace_valid), 32'd0);
    chk("ov_sticky", 32'(m_if.overflow),   32'd1);

    // halt: PC held at 0x3010 for 4 cycles with 2 entries queued
    m_if.trace_ready = 1'b0;
    hold_pc = 1'b1;
    m_if.pc_in = 32'h3010;
    m_if.grf_we = 1'b1; m_if.grf_addr = 5'd3; m_if.grf_wdata = 32'h33;
    m_if.dm_we = 1'b1; m_if.dm_addr = 32'h20; m_if.dm_wdata = 32'h44;
    tick();
    m_if.grf_we = 1'b0; m_if.dm_we = 1'b0;
    chk("h_valid", 32'(m_if.trace_valid), 32'd1);
    tick();
    tick();
    chk("h_still_running", 32'(m_if.running), 32'd1);
    tick();
    chk("h_drain_running",   32'(m_if.running),   32'd0);
    chk("h_drain_cpu_reset", 32'(m_if.cpu_reset), 32'd1);
    chk("h_drain_done",      32'(m_if.done),      32'd0);
    chk("h_drain_head",      m_if.trace_data,     32'h33);
    m_if.grf_we = 1'b1; m_if.grf_addr = 5'd5; m_if.grf_wdata = 32'h55;
    m_if.trace_ready = 1'b1;
    tick();
    m_if.grf_we = 1'b0;
    chk("h_pop_kind", 32'(m_if.trace_kind), 32'd1);
    chk("h_pop_addr", m_if.trace_addr, 32'h20);
    chk("h_pop_data", m_if.trace_data, 32'h44);
    tick();
    chk("h_empty",      32'(m_if.trace_valid), 32'd0);
    chk("h_not_done",   32'(m_if.done),        32'd0);
    tick();
    chk("h_done",       32'(m_if.done),        32'd1);
    chk("h_timeout",    32'(m_if.timeout),     32'd0);
    chk("h_cpu_reset",  32'(m_if.cpu_reset),   32'd1);
    chk("h_running",    32'(m_if.running),     32'd0);

    // timeout instance has long since terminated
    chk("to_timeout",   32'(t_if.timeout),   32'd1);
    chk("to_done",      32'(t_if.done),      32'd0);
    chk("to_cycle",     t_if.cycle_cnt,      32'd20);
    chk("to_running",   32'(t_if.running),   32'd0);
    chk("to_cpu_reset", 32'(t_if.cpu_reset), 32'd1);

    // reset mid-terminal returns everything to reset values
    reset = 1'b1;
    tick();
    chk("rr_to_timeout", 32'(t_if.timeout),   32'd0);
    chk("rr_to_cycle",   t_if.cycle_cnt,      32'd0);
    chk("rr_to_cpu_rst", 32'(t_if.cpu_reset), 32'd1);
    chk("rr_m_done",     32'(m_if.done),      32'd0);
    chk("rr_m_overflow", 32'(m_if.overflow),  32'd0);
    chk("rr_m_valid",    32'(m_if.trace_valid), 32'd0);
    chk("rr_m_cycle",    m_if.cycle_cnt,      32'd0);
    reset = 1'b0;
    tick();
    chk("rr_hold_cpu_rst", 32'(m_if.cpu_reset), 32'd1);
    chk("rr_hold_running", 32'(m_if.running),   32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/cpu_run_ctrl.md
Name: cpu_run_ctrl

Overview:
Synthesizable run controller and write-trace buffer between the bench clock/reset source and the CPU under test (single-cycle or pipelined MIPS).
- Stretches the external reset into a configurable CPU reset pulse.
- Counts run cycles and detects program halt (PC self-loop) or timeout.
- Serialises register-file and data-memory writes from two capture channels into one FIFO-buffered trace stream with valid/ready handshake.

Parameters:
RST_CYCLES, 5, cycles cpu_reset is held high after reset deasserts (>=1)
TIMEOUT, 100000, run-cycle limit before forced stop
HALT_REPEAT, 4, consecutive cycles with unchanged pc_in that declare halt (>=2)
FIFO_DEPTH, 8, trace entries buffered (power of two, >=2)
CNT_W, 32, cycle counter width

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  synchronous active-high reset
cpu_reset  out  1  reset driven to the CPU
pc_in  in  32  CPU PC of the committing instruction
grf_we  in  1  register write enable (channel 0)
grf_addr  in  5  register number
grf_wdata  in  32  register write data
dm_we  in  1  data memory write enable (channel 1)
dm_addr  in  32  byte address
dm_wdata  in  32  memory write data
trace_valid  out  1  trace entry available
trace_ready  in  1  consumer accepts entry
trace_kind  out  1  0 = GRF, 1 = DM
trace_pc  out  32  PC of the write
trace_addr  out  32  register number zero-extended, or memory address
trace_data  out  32  written value
cycle_cnt  out  CNT_W  cycles spent in RUN
running  out  1  high in RUN
done  out  1  halt detected and trace drained (sticky)
timeout  out  1  TIMEOUT reached (sticky)
overflow  out  1  at least one trace entry dropped (sticky)

Behaviour:
- Reset (while reset=1):
  - State HOLD; hold counter 0; cpu_reset=1; cycle_cnt=0; FIFO empty.
  - trace_valid=0; running/done/timeout/overflow=0.
  - Reset asserted mid-run aborts everything and returns to these values on the next edge.
- States:
  - HOLD: cpu_reset=1 for RST_CYCLES edges after reset falls, then RUN.
  - RUN: cpu_reset=0; cycle_cnt increments each cycle; capture enabled.
  - DRAIN: capture disabled; cpu_reset=1 (freezes CPU); wait for FIFO empty.
  - DONE / TOUT: terminal until reset; cpu_reset=1.
- Halt detection:
  - Per-cycle flag: in RUN, pc_in equals the previous cycle's pc_in.
  - Counter increments on each such cycle and clears on any PC change.
  - When the counter reaches HALT_REPEAT-1 → DRAIN.
  - On DRAIN with FIFO empty, the next cycle enters DONE with done=1.
- Timeout:
  - In RUN, if cycle_cnt == TIMEOUT-1 at an edge → DRAIN with a timeout tag; terminal state is TOUT with timeout=1.
  - If halt and timeout occur in the same cycle, halt wins (done, not timeout).
- Capture (RUN only; writes in the cycle of the state change are still captured):
  - grf_we with grf_addr=0 is discarded (not traced, not overflow).
  - Both channels active → two entries enqueued in one cycle, GRF first.
  - Enqueue succeeds only if free slots >= entries needed this cycle, counting a same-cycle dequeue as freeing a slot.
  - Otherwise the whole cycle's entries are dropped and overflow=1. No partial enqueue.
- FIFO and handshake:
  - Entry = {kind, pc, addr, data}.
  - Head pops when trace_valid & trace_ready.
  - Outputs come directly from the head entry; trace_valid = FIFO non-empty.
  - Head is stable while valid & !ready.
  - Pointers wrap modulo FIFO_DEPTH; full/empty are distinguished by an occupancy counter 0..FIFO_DEPTH.
  - Enqueue-to-visible latency is 1 cycle (written at edge, valid after).
- cycle_cnt saturates at all-ones and does not wrap.

Test Plan:
- Reset 3 cycles, then release, RST_CYCLES=5 → cpu_reset high exactly 5 edges after release; running rises on the 6th; cycle_cnt=0 at first RUN cycle.
- GRF write $8=0x1234 at pc 0x3000, trace_ready=1 → one entry {0,0x3000,8,0x1234} valid one cycle later; GRF write to $0 → no entry.
- Same-cycle GRF $1=0xA and DM [0x10]=0xB, trace_ready=0 → two entries, GRF first; head is held while ready=0, then both pop in order.
- trace_ready=0 with FIFO_DEPTH=8: 7 entries queued, then a dual write → both dropped, overflow=1, occupancy stays 7.
- pc_in held at 0x3010 for 4 cycles with 2 entries queued → DRAIN, cpu_reset=1; done=1 the cycle after the last pop; timeout=0.
- TIMEOUT=20 with PC always changing → timeout=1 after drain; cycle_cnt=20; then reset mid-TOUT → all outputs return to reset values.
